z80_bus_mem: RTL

Z80_BUS_MEM -- requirements
Module: z80_bus_mem

---
 rtl/z80_bus_pkg.sv | 16 +
 rtl/z80_bus_mem_if.sv | 9 +
 rtl/z80_trace_fifo.sv | 43 ++++
 rtl/z80_bus_mem.sv | 93 +++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared bus-cycle decode, wait FSM states and trace entry format
package z80_bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        io;
  } trace_t;
  localparam int TRACE_W = $bits(trace_t);
  function automatic logic mem_cyc(input logic mreq_n, rfsh_n, rd_n, wr_n);
    return !mreq_n && rfsh_n && (!rd_n || !wr_n);
  endfunction
  function automatic logic io_cyc(input logic iorq_n, m1_n, rd_n, wr_n);
    return !iorq_n && m1_n && (!rd_n || !wr_n);
  endfunction
endpackage

// File: rtl/z80_bus_mem_if.sv
// z80_bus_mem_if: Z80 CPU bus strobes, address/data and wait request
interface z80_bus_mem_if;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  wdata, rdata;
  logic        wait_n;
  modport master(output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, wdata, input rdata, wait_n);
  modport slave(input m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, wdata, output rdata, wait_n);
endinterface

// File: rtl/z80_trace_fifo.sv
// z80_trace_fifo: power-of-two FIFO with sticky overflow flag
module z80_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   ovf_clr,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_push;
  assign valid   = count != '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];
  // entry storage, written only on an accepted push
  always_ff @(posedge clk)
    if (do_push) store[wr_ptr] <= din;
  // pointers wrap naturally; an overflowing push beats a same-edge clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
      ovf    <= (push && full && !pop) || (ovf && !ovf_clr);
    end
endmodule

// File: rtl/z80_bus_mem.sv
// z80_bus_mem: Z80 bus memory with I/O window, wait states, backdoor and write trace
module z80_bus_mem import z80_bus_pkg::*; #(
  parameter int         MEM_AW      = 16,
  parameter logic [7:0] IO_BASE     = 8'h10,
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 1,
  parameter int         TRACE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  z80_bus_mem_if.slave                 bus,
  input  logic                         bd_we,
  input  logic [15:0]                  bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata,
  input  logic                         tr_pop,
  output logic                         tr_valid,
  output logic [15:0]                  tr_addr,
  output logic [7:0]                   tr_data,
  output logic                         tr_io,
  output logic [$clog2(TRACE_DEPTH):0] tr_count,
  output logic                         tr_ovf,
  input  logic                         tr_ovf_clr
);
  logic [7:0]  mem [2**MEM_AW];
  logic        mc, ic, cyc, wq, wr_seen, bd_pend;
  logic [15:0] ea, bd_a;
  logic [7:0]  bd_d;
  logic [3:0]  cnt, ws;
  state_t      state;
  trace_t      entry, head;
  assign mc       = mem_cyc(bus.mreq_n, bus.rfsh_n, bus.rd_n, bus.wr_n);
  assign ic       = io_cyc(bus.iorq_n, bus.m1_n, bus.rd_n, bus.wr_n);
  assign cyc      = mc || ic;
  assign wq       = cyc && !bus.wr_n;
  assign ea       = bus.iorq_n ? bus.A : {IO_BASE, bus.A[7:0]};
  assign ws       = ic ? 4'(IO_WAIT) : 4'(MEM_WAIT);
  assign bd_rdata = mem[bd_addr[MEM_AW-1:0]];
  assign entry    = '{addr: ea, data: bus.wdata, io: ic};
  assign {tr_addr, tr_data, tr_io} = head;
  // backdoor request captured on the rising edge; committed on the next falling edge so one process owns the array
  always_ff @(posedge clk)
    {bd_pend, bd_a, bd_d} <= {bd_we, bd_addr, bd_wdata};
  // array writes: backdoor first, then the bus write so the bus wins on a shared address
  always_ff @(negedge clk) begin
    if (bd_pend) mem[bd_a[MEM_AW-1:0]] <= bd_d;
    if (wq) mem[ea[MEM_AW-1:0]] <= bus.wdata;
  end
  // read data follows the effective address on every falling edge
  always_ff @(negedge clk or posedge reset)
    if (reset) bus.rdata <= 8'h00;
    else bus.rdata <= mem[ea[MEM_AW-1:0]];
  // wait-state FSM with registered wait_n
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.wait_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (cyc) begin
          cnt        <= ws;
          state      <= ws != '0 ? WAIT : HOLD;
          bus.wait_n <= ws == '0;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= HOLD;
            bus.wait_n <= 1'b1;
          end
        end
        HOLD: if (!cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // remembers that the current write cycle has already been traced
  always_ff @(posedge clk or posedge reset)
    if (reset) wr_seen <= 1'b0;
    else wr_seen <= wq;
  z80_trace_fifo #(.DEPTH(TRACE_DEPTH), .W(TRACE_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wq && !wr_seen),
    .pop     (tr_pop),
    .ovf_clr (tr_ovf_clr),
    .din     (entry),
    .dout    (head),
    .valid   (tr_valid),
    .ovf     (tr_ovf),
    .count   (tr_count)
  );
endmodule
